// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;

  // Source selected by the priority mux, highest priority last.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_RAS,
    SRC_REDIRECT,
    SRC_TRAP
  } pc_src_t;

endpackage

// File: rtl/pc_gen_return_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// the count saturates at RAS_DEPTH and a pop on an empty stack is ignored.
module return_addr_stack #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            clear,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   ptr;      // next slot to write; ptr-1 is the top
  logic [PW-1:0]   top_idx;
  logic            empty;
  logic            full;
  logic            swap;     // push+pop on a non-empty stack replaces the top

  assign top_idx = ptr - PW'(1);
  assign top     = entries[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign swap    = push && pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (swap) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // NOTE: the entry array has no reset; contents are meaningless until the
  // pointer/count say otherwise, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (!clear) begin
      if (swap)      entries[top_idx] <= push_data;
      else if (push) entries[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: registered PC chosen by fixed priority among trap,
// execute redirect, return-address-stack prediction, stall hold and increment.
module pc_gen
  import pc_pkg::*;
#(
  parameter  int              XLEN         = 32,
  parameter  logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter  int              ILEN_BYTES   = 4,
  parameter  int              RAS_DEPTH    = 4,
  localparam int              ALIGN_BITS   = $clog2(ILEN_BYTES),
  localparam int              CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            redirected,
  output logic [CW-1:0]   ras_count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  pc_src_t         src;
  logic [XLEN-1:0] pc_d;
  logic            redirected_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_en;
  logic            ras_hit;

  // Stack traffic is wrong-path under a trap/redirect and must wait out a stall.
  assign ras_en  = !trap_valid && !redirect_valid && !stall;
  assign ras_hit = ras_pop && !stall && (ras_count != '0);

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push && ras_en),
    .push_data (ras_push_addr),
    .pop       (ras_pop && ras_en),
    .clear     (trap_valid),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign pc_next_seq = pc + XLEN'(ILEN_BYTES);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src = SRC_SEQ;
    if (trap_valid)          src = SRC_TRAP;
    else if (redirect_valid) src = SRC_REDIRECT;
    else if (ras_hit)        src = SRC_RAS;
    else if (stall)          src = SRC_HOLD;
  end

  always_comb begin
    pc_d = pc_next_seq;
    unique case (src)
      SRC_TRAP:     pc_d = trap_vector & ALIGN_MASK;
      SRC_REDIRECT: pc_d = redirect_target & ALIGN_MASK;
      SRC_RAS:      pc_d = ras_top & ALIGN_MASK;
      SRC_HOLD:     pc_d = pc;
      default:      pc_d = pc_next_seq;
    endcase
  end

  assign redirected_d = (src == SRC_TRAP) || (src == SRC_REDIRECT) || (src == SRC_RAS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      redirected <= 1'b0;
    end else begin
      pc         <= pc_d;
      redirected <= redirected_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RV    = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        redirected;
  logic [2:0]  ras_count;

  pc_gen dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ras_pop         (ras_pop),
    .pc              (pc),
    .pc_next_seq     (pc_next_seq),
    .redirected      (redirected),
    .ras_count       (ras_count)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: the stack is a queue whose back is the top.
  logic [31:0] m_pc;
  logic        m_red;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_pc  = RV;
    m_red = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    bit en;
    en = !trap_valid && !redirect_valid && !stall;
    if (trap_valid) begin
      m_pc = align(trap_vector); m_red = 1'b1; m_ras.delete();
    end else if (redirect_valid) begin
      m_pc = align(redirect_target); m_red = 1'b1;
    end else if (ras_pop && !stall && m_ras.size() > 0) begin
      m_pc = align(m_ras[$]); m_red = 1'b1;
    end else if (stall) begin
      m_red = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4; m_red = 1'b0;
    end
    if (en) begin
      if (ras_push && ras_pop && m_ras.size() > 0) begin
        m_ras[$] = ras_push_addr;
      end else if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic idle();
    stall = 1'b0; trap_valid = 1'b0; trap_vector = '0;
    redirect_valid = 1'b0; redirect_target = '0;
    ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
  endtask

  // One clock edge: model follows the same inputs, outputs sampled 1 ns later.
  task automatic step(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check({tag, ".pc"},  pc, m_pc);
    check({tag, ".red"}, 32'(redirected), 32'(m_red));
    check({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
    check({tag, ".seq"}, pc_next_seq, m_pc + 32'd4);
    @(negedge clock);
    idle();
  endtask

  task automatic push_step(input string tag, input logic [31:0] a);
    ras_push = 1'b1; ras_push_addr = a;
    step(tag);
  endtask

  task automatic pop_step(input string tag);
    ras_pop = 1'b1;
    step(tag);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst.pc",  pc, RV);
    check("rst.red", 32'(redirected), 32'd0);
    check("rst.cnt", 32'(ras_count), 32'd0);
    reset = 1'b0;

    // Stepping, then an asynchronous reset mid-run.
    for (int i = 0; i < 4; i++) step("seq");
    check("seq.at10", pc, 32'h0040_0010);
    push_step("pre_rst_push", 32'h0040_0abc);
    reset = 1'b1;
    #1;
    check("arst.pc",  pc, RV);
    check("arst.cnt", 32'(ras_count), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step("rel1");
    check("rel1.const", pc, 32'h0040_0004);
    step("rel2");
    check("rel2.const", pc, 32'h0040_0008);

    // Stall holds; redirect overrides stall and is aligned.
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      step("stall");
    end
    check("stall.const", pc, 32'h0040_0008);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
    step("st_redir");
    check("st_redir.const", pc, 32'h0040_0100);
    step("after_redir");
    check("after_redir.red", 32'(redirected), 32'd0);

    // Trap beats redirect and clears the stack.
    push_step("trap_pre", 32'h0040_0200);
    trap_valid = 1'b1; trap_vector = 32'h8000_0000;
    redirect_valid = 1'b1; redirect_target = 32'h1234_5678;
    step("trap");
    check("trap.const", pc, 32'h8000_0000);
    check("trap.cnt0",  32'(ras_count), 32'd0);

    // Round trip, including pop on empty.
    push_step("rt_push1", 32'h0040_0020);
    push_step("rt_push2", 32'h0040_0040);
    pop_step("rt_pop1");
    check("rt_pop1.const", pc, 32'h0040_0040);
    pop_step("rt_pop2");
    check("rt_pop2.const", pc, 32'h0040_0020);
    pop_step("rt_pop3");

    // Overflow drops the oldest entry.
    for (int i = 1; i <= 5; i++) push_step("ov_push", 32'(i) << 8);
    check("ov.cnt4", 32'(ras_count), 32'd4);
    for (int i = 0; i < 5; i++) pop_step("ov_pop");

    // Simultaneous push+pop: empty acts as push, non-empty swaps the top.
    ras_push = 1'b1; ras_push_addr = 32'h0000_7000; ras_pop = 1'b1;
    step("pp_empty");
    ras_push = 1'b1; ras_push_addr = 32'h0000_8000; ras_pop = 1'b1;
    step("pp_swap");
    check("pp_swap.const", pc, 32'h0000_7000);
    pop_step("pp_after");

    // Gating: push under a redirect is discarded; pop under stall holds.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    ras_push = 1'b1; ras_push_addr = 32'h0000_9000;
    step("gate_redir");
    step("wrap");
    check("wrap.const", pc, 32'h0000_0000);
    stall = 1'b1; ras_pop = 1'b1;
    step("gate_stall");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      trap_valid      = ($urandom_range(31) == 0);
      trap_vector     = $urandom;
      redirect_valid  = ($urandom_range(9) == 0);
      redirect_target = $urandom;
      stall           = ($urandom_range(4) == 0);
      ras_push        = ($urandom_range(3) == 0);
      ras_push_addr   = $urandom;
      ras_pop         = ($urandom_range(3) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
